// File: rtl/rv32_pkg.sv
// Shared rv32 definitions: register-file sequencing states, default sizes, register index type.
package rv32_pkg;

    localparam int XLEN_DEFAULT      = 32;
    localparam int REG_COUNT_DEFAULT = 32;

    typedef enum logic {
        REGFILE_CLEAR,
        REGFILE_READY
    } regfile_state_t;

    typedef logic [$clog2(REG_COUNT_DEFAULT)-1:0] reg_idx_t;

endpackage

// File: rtl/rv32_regfile_clear.sv
// Post-reset clear sequencer: walks registers 1..REG_COUNT-1 writing zero, then raises ready.
// state         | meaning
// REGFILE_CLEAR | zeroing register[count], one per edge; writes/reads blocked
// REGFILE_READY | normal operation
module rv32_regfile_clear
    import rv32_pkg::*;
#(
    parameter int  REG_COUNT = REG_COUNT_DEFAULT,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic          clear_active,
    output logic [AW-1:0] clear_addr,
    output logic          ready
);

    regfile_state_t state;
    logic [AW-1:0]  count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= REGFILE_CLEAR;
            count <= AW'(1);
            ready <= 1'b0;
        end else begin
            unique case (state)
                REGFILE_CLEAR: begin
                    count <= count + 1'b1;
                    if (count == AW'(REG_COUNT - 1)) begin
                        state <= REGFILE_READY;
                        ready <= 1'b1;
                    end
                end
                REGFILE_READY: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= REGFILE_CLEAR;
                    count <= AW'(1);
                    ready <= 1'b0;
                end
            endcase
        end
    end

    assign clear_active = (state == REGFILE_CLEAR);
    assign clear_addr   = count;

endmodule

// File: rtl/rv32_regfile.sv
// Multi-port integer register file with hardware clear, read hold and x0 hardwired to zero.
// Same-edge write-to-read forwarding is built only when RV32_REGFILE_BYPASS_EN is defined.
module rv32_regfile
    import rv32_pkg::*;
#(
    parameter int  XLEN       = XLEN_DEFAULT,
    parameter int  REG_COUNT  = REG_COUNT_DEFAULT,
    parameter int  READ_PORTS = 2,
    localparam int AW         = $clog2(REG_COUNT)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [READ_PORTS*AW-1:0]   rs_in,
    input  logic                       read_en_in,
    input  logic [AW-1:0]              rd_in,
    input  logic                       rd_writeback_in,
    input  logic [XLEN-1:0]            rd_value_in,
    output logic [READ_PORTS*XLEN-1:0] rs_value_out,
    output logic                       ready_out
);

    logic          clear_active;
    logic [AW-1:0] clear_addr;
    logic          ready;

    rv32_regfile_clear #(
        .REG_COUNT (REG_COUNT)
    ) u_clear (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_active (clear_active),
        .clear_addr   (clear_addr),
        .ready        (ready)
    );

    assign ready_out = ready;

    // Storage has no reset; only the clear sequence zeroes it.
    logic [XLEN-1:0] regs [REG_COUNT];

    always_ff @(posedge clk) begin
        if (clear_active) begin
            regs[clear_addr] <= '0;
        end else if (rd_writeback_in && (rd_in != '0)) begin
            regs[rd_in] <= rd_value_in;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] q;

        assign addr = rs_in[p*AW +: AW];

        always_comb begin
            data = regs[addr];
            if (addr == '0) begin
                data = '0;
`ifdef RV32_REGFILE_BYPASS_EN
            end else if (rd_writeback_in && (rd_in == addr)) begin
                data = rd_value_in;
`endif
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                q <= '0;
            end else if (ready && read_en_in) begin
                q <= data;
            end
        end

        assign rs_value_out[p*XLEN +: XLEN] = q;
    end

endmodule
